rx_sample_timer: RTL and testbench

RX_SAMPLE_TIMER -- requirements
Module: rx_sample_timer

---
 rtl/rx_sample_timer.sv | 176 +++++++++++++++++
 tb/tb_rx_sample_timer.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_sample_timer.sv
// rx_sample_timer: per-bit / per-frame timing for a UART-style receiver.
// Counts clocks within a bit (edge_cnt) and bits within a frame (bit_cnt),
// emitting three mid-bit oversample strobes, a bit_end and a frame_done.
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   enable              count enable; low = idle, reload config, clear
//   prescale            clocks per bit (legal 4..2^PRESCALE_W-1)
//   frame_bits          bits per frame; 0 means 2^BIT_CNT_W
//   edge_cnt, bit_cnt   registered counters
//   sample_strb/_idx    mid-bit oversample strobe and its index 0/1/2
//   bit_end, frame_done last clock of a bit / of a frame
//   cfg_err             illegal prescale flag (RX_TIMER_CFG_ERR_EN only)
// Build option: define RX_TIMER_CFG_ERR_EN to flag prescale<4 instead of
// clamping it to 4 at load time.
module rx_sample_timer #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [BIT_CNT_W-1:0]  frame_bits,
  output logic [PRESCALE_W-1:0] edge_cnt,
  output logic [BIT_CNT_W-1:0]  bit_cnt,
  output logic                  sample_strb,
  output logic [1:0]            sample_idx,
  output logic                  bit_end,
  output logic                  frame_done
`ifdef RX_TIMER_CFG_ERR_EN
  ,
  output logic                  cfg_err
`endif
);

  localparam logic [PRESCALE_W-1:0] PRESC_MIN =
    PRESCALE_W'(4);
  localparam logic [PRESCALE_W-1:0] PRESC_RST =
    PRESCALE_W'(4);
  localparam logic [BIT_CNT_W-1:0] FBITS_RST =
    BIT_CNT_W'(10);
  localparam logic [PRESCALE_W-1:0] P_ONE =
    PRESCALE_W'(1);
  localparam logic [BIT_CNT_W-1:0] B_ONE =
    BIT_CNT_W'(1);

  logic [PRESCALE_W-1:0] presc_q;
  logic [PRESCALE_W-1:0] presc_d;
  logic [BIT_CNT_W-1:0]  fbits_q;
  logic [BIT_CNT_W-1:0]  fbits_d;
  logic [PRESCALE_W-1:0] edge_q;
  logic [PRESCALE_W-1:0] edge_d;
  logic [BIT_CNT_W-1:0]  bit_q;
  logic [BIT_CNT_W-1:0]  bit_d;

  logic [PRESCALE_W-1:0] presc_load;
  logic [PRESCALE_W-1:0] presc_last;
  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] mid_lo;
  logic [PRESCALE_W-1:0] mid_hi;
  logic [BIT_CNT_W-1:0]  fbits_last;
  logic                  edge_last;
  logic                  bit_last;
  logic                  cfg_bad;
  logic                  run;

`ifdef RX_TIMER_CFG_ERR_EN
  logic err_q;
  logic err_d;

  // An illegal prescale is latched only while
  // enabled; it then sticks until enable drops.
  assign cfg_bad = err_q || (presc_q < PRESC_MIN);
  assign presc_load = prescale;
  assign cfg_err = err_q;
`else
  assign cfg_bad = 1'b0;
  assign presc_load = (prescale < PRESC_MIN) ?
                      PRESC_MIN : prescale;
`endif

  assign presc_last = presc_q - P_ONE;
  assign mid        = presc_q >> 1;
  assign mid_lo     = mid - P_ONE;
  assign mid_hi     = mid + P_ONE;
  // Natural wrap: frame_bits=0 gives all-ones,
  // i.e. a 2^BIT_CNT_W-bit frame.
  assign fbits_last = fbits_q - B_ONE;
  assign edge_last  = (edge_q == presc_last);
  assign bit_last   = (bit_q == fbits_last);

  assign run = enable && !reset && !cfg_bad;

  always_comb begin
    presc_d = presc_q;
    fbits_d = fbits_q;
    edge_d  = edge_q;
    bit_d   = bit_q;
`ifdef RX_TIMER_CFG_ERR_EN
    err_d   = err_q;
`endif
    if (!enable) begin
      presc_d = presc_load;
      fbits_d = frame_bits;
      edge_d  = '0;
      bit_d   = '0;
`ifdef RX_TIMER_CFG_ERR_EN
      err_d   = 1'b0;
`endif
    end else if (cfg_bad) begin
      edge_d  = '0;
      bit_d   = '0;
`ifdef RX_TIMER_CFG_ERR_EN
      err_d   = 1'b1;
`endif
    end else if (edge_last) begin
      edge_d = '0;
      bit_d  = bit_last ? '0 : bit_q + B_ONE;
    end else begin
      edge_d = edge_q + P_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= PRESC_RST;
      fbits_q <= FBITS_RST;
      edge_q  <= '0;
      bit_q   <= '0;
`ifdef RX_TIMER_CFG_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      presc_q <= presc_d;
      fbits_q <= fbits_d;
      edge_q  <= edge_d;
      bit_q   <= bit_d;
`ifdef RX_TIMER_CFG_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    sample_strb = 1'b0;
    sample_idx  = 2'd0;
    bit_end     = 1'b0;
    frame_done  = 1'b0;
    if (run) begin
      unique case (1'b1)
        (edge_q == mid_lo): begin
          sample_strb = 1'b1;
          sample_idx  = 2'd0;
        end
        (edge_q == mid): begin
          sample_strb = 1'b1;
          sample_idx  = 2'd1;
        end
        (edge_q == mid_hi): begin
          sample_strb = 1'b1;
          sample_idx  = 2'd2;
        end
        default: begin
          sample_strb = 1'b0;
          sample_idx  = 2'd0;
        end
      endcase
      bit_end    = edge_last;
      frame_done = edge_last && bit_last;
    end
  end

  assign edge_cnt = edge_q;
  assign bit_cnt  = bit_q;

endmodule

// File: tb/tb_rx_sample_timer.sv
// tb_rx_sample_timer: randomized and directed checks of rx_sample_timer
// against a cycle-count reference model (edge = k mod P, bit = k/P mod F).
module tb_rx_sample_timer;

  localparam int PW = 6;
  localparam int BW = 4;
  localparam int VW = PW + BW + 5;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [PW-1:0] prescale = 6'd8;
  logic [BW-1:0] frame_bits = 4'd10;
  logic [PW-1:0] edge_cnt;
  logic [BW-1:0] bit_cnt;
  logic          sample_strb;
  logic [1:0]    sample_idx;
  logic          bit_end;
  logic          frame_done;
`ifdef RX_TIMER_CFG_ERR_EN
  logic          cfg_err;
`endif

  always #5 clk = ~clk;

  rx_sample_timer #(
    .PRESCALE_W(PW),
    .BIT_CNT_W (BW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .prescale   (prescale),
    .frame_bits (frame_bits),
    .edge_cnt   (edge_cnt),
    .bit_cnt    (bit_cnt),
    .sample_strb(sample_strb),
    .sample_idx (sample_idx),
    .bit_end    (bit_end),
`ifdef RX_TIMER_CFG_ERR_EN
    .frame_done (frame_done),
    .cfg_err    (cfg_err)
`else
    .frame_done (frame_done)
`endif
  );

  int n_pass = 0;
  int n_total = 0;

  // model: k = clocks counted since last clear,
  // p / f = latched bit period and frame length
  int k = 0;
  int p = 4;
  int f = 10;
  bit m_err = 1'b0;

  int e_edge, e_bit, e_idx;
  bit e_strb, e_end, e_done;
  logic [VW-1:0] exp_vec;
  logic [VW-1:0] dut_vec;

  assign dut_vec = {edge_cnt, bit_cnt, sample_strb,
                    sample_idx, bit_end, frame_done};

  task automatic model_eval();
    int mid;
    bit act;
    act = enable && !reset;
    if (p < 4) begin
      act = 1'b0;
      e_edge = 0;
      e_bit = 0;
    end else begin
      e_edge = k % p;
      e_bit = (k / p) % f;
    end
    mid = p / 2;
    e_strb = act && e_edge >= mid - 1 && e_edge <= mid + 1;
    e_idx = e_strb ? e_edge - (mid - 1) : 0;
    e_end = act && e_edge == p - 1;
    e_done = e_end && e_bit == f - 1;
    exp_vec = {PW'(e_edge), BW'(e_bit), e_strb,
               2'(e_idx), e_end, e_done};
  endtask

  task automatic drive(input logic r, input logic en,
                       input logic [PW-1:0] ps,
                       input logic [BW-1:0] fb);
    reset = r;
    enable = en;
    prescale = ps;
    frame_bits = fb;
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    @(posedge clk);
    if (reset) begin
      k = 0; p = 4; f = 10; m_err = 1'b0;
    end else if (!enable) begin
      k = 0;
      m_err = 1'b0;
`ifdef RX_TIMER_CFG_ERR_EN
      p = int'(prescale);
`else
      p = (prescale < 4) ? 4 : int'(prescale);
`endif
      f = (frame_bits == 0) ? (1 << BW) : int'(frame_bits);
    end else if (p < 4) begin
      m_err = 1'b1;
    end else begin
      k++;
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 6'd8, 4'd10);
    n_total++;
    if (dut_vec !== exp_vec)
      $display("FAIL reset_hold: got %h want %h", dut_vec, exp_vec);
    else n_pass++;
    advance();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 6'd8, 4'd10);
      n_total++;
      if (dut_vec !== exp_vec)
        $display("FAIL reset_p4 i=%0d: got %h want %h",
                 i, dut_vec, exp_vec);
      else n_pass++;
      advance();
    end
  endtask

  task automatic test_frame_p8();
    int n_done, done_at, n_end;
    n_done = 0; done_at = -1; n_end = 0;
    drive(1'b0, 1'b0, 6'd8, 4'd10);
    advance();
    for (int i = 0; i < 80; i++) begin
      drive(1'b0, 1'b1, 6'd8, 4'd10);
      n_total++;
      if (dut_vec !== exp_vec)
        $display("FAIL frame_p8 i=%0d: got %h want %h",
                 i, dut_vec, exp_vec);
      else n_pass++;
      if (frame_done) begin n_done++; done_at = i + 1; end
      if (bit_end) n_end++;
      advance();
    end
    n_total++;
    if (n_done != 1 || done_at != 80)
      $display("FAIL frame_p8_done: got %0d pulses at %0d want 1 at 80",
               n_done, done_at);
    else n_pass++;
    n_total++;
    if (n_end != 10)
      $display("FAIL frame_p8_bitend: got %0d want 10", n_end);
    else n_pass++;
    drive(1'b0, 1'b0, 6'd8, 4'd10);
    n_total++;
    if (bit_cnt !== 4'd0 || edge_cnt !== 6'd0)
      $display("FAIL frame_p8_wrap: got %0d/%0d want 0/0",
               edge_cnt, bit_cnt);
    else n_pass++;
    advance();
  endtask

  task automatic test_back_to_back();
    int d0, d1, nd;
    d0 = -1; d1 = -1; nd = 0;
    drive(1'b0, 1'b0, 6'd16, 4'd11);
    advance();
    for (int i = 0; i < 352; i++) begin
      drive(1'b0, 1'b1, 6'd16, 4'd11);
      n_total++;
      if (dut_vec !== exp_vec)
        $display("FAIL b2b i=%0d: got %h want %h",
                 i, dut_vec, exp_vec);
      else n_pass++;
      if (frame_done) begin
        nd++;
        if (d0 < 0) d0 = i; else d1 = i;
      end
      advance();
    end
    n_total++;
    if (nd != 2 || d0 != 175 || d1 - d0 != 176)
      $display("FAIL b2b_done: got %0d pulses at %0d,%0d want 2 at 175,351",
               nd, d0, d1);
    else n_pass++;
  endtask

  task automatic test_presc_change();
    int n_end, first_end;
    logic [PW-1:0] ps;
    n_end = 0; first_end = -1;
    drive(1'b0, 1'b0, 6'd8, 4'd10);
    advance();
    for (int i = 0; i < 40; i++) begin
      ps = (i < 12) ? 6'd8 : 6'd16;
      drive(1'b0, 1'b1, ps, 4'd10);
      n_total++;
      if (dut_vec !== exp_vec)
        $display("FAIL presc_chg i=%0d: got %h want %h",
                 i, dut_vec, exp_vec);
      else n_pass++;
      if (bit_end) n_end++;
      advance();
    end
    n_total++;
    if (n_end != 5)
      $display("FAIL presc_chg_hold: got %0d bit_ends want 5", n_end);
    else n_pass++;
    drive(1'b0, 1'b0, 6'd16, 4'd10);
    advance();
    for (int i = 0; i < 32; i++) begin
      drive(1'b0, 1'b1, 6'd16, 4'd10);
      n_total++;
      if (dut_vec !== exp_vec)
        $display("FAIL presc_new i=%0d: got %h want %h",
                 i, dut_vec, exp_vec);
      else n_pass++;
      if (bit_end && first_end < 0) first_end = i;
      advance();
    end
    n_total++;
    if (first_end != 15)
      $display("FAIL presc_new_period: got %0d want 15", first_end);
    else n_pass++;
  endtask

  task automatic test_enable_drop();
    drive(1'b0, 1'b0, 6'd8, 4'd10);
    advance();
    for (int i = 0; i < 29; i++) begin
      drive(1'b0, 1'b1, 6'd8, 4'd10);
      advance();
    end
    drive(1'b0, 1'b0, 6'd8, 4'd10);
    n_total++;
    if (edge_cnt !== 6'd5 || bit_cnt !== 4'd3 || sample_strb !== 1'b0)
      $display("FAIL en_drop_pre: got %0d/%0d strb %b want 5/3 strb 0",
               edge_cnt, bit_cnt, sample_strb);
    else n_pass++;
    advance();
    drive(1'b0, 1'b0, 6'd8, 4'd10);
    n_total++;
    if (dut_vec !== exp_vec || edge_cnt !== 6'd0 || bit_cnt !== 4'd0)
      $display("FAIL en_drop_clr: got %h want %h", dut_vec, exp_vec);
    else n_pass++;
    advance();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 6'd8, 4'd10);
      if (i == 7) begin
        n_total++;
        if (bit_end !== 1'b1 || dut_vec !== exp_vec)
          $display("FAIL en_fall_bitend: got %h want %h",
                   dut_vec, exp_vec);
        else n_pass++;
      end
      advance();
    end
    drive(1'b0, 1'b0, 6'd8, 4'd10);
    advance();
    drive(1'b0, 1'b0, 6'd8, 4'd10);
    n_total++;
    if (edge_cnt !== 6'd0 || bit_cnt !== 4'd0 || bit_end !== 1'b0)
      $display("FAIL en_fall_clr: got %0d/%0d end %b want 0/0 end 0",
               edge_cnt, bit_cnt, bit_end);
    else n_pass++;
    advance();
  endtask

  task automatic test_reset_mid();
    int first_end;
    first_end = -1;
    drive(1'b0, 1'b0, 6'd8, 4'd10);
    advance();
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, 1'b1, 6'd8, 4'd10);
      advance();
    end
    drive(1'b1, 1'b1, 6'd8, 4'd10);
    n_total++;
    if (sample_strb !== 1'b0 || sample_idx !== 2'd0 ||
        bit_end !== 1'b0 || frame_done !== 1'b0)
      $display("FAIL rst_mid_strb: got %b%0d%b%b want 0000",
               sample_strb, sample_idx, bit_end, frame_done);
    else n_pass++;
    advance();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, 6'd8, 4'd10);
      n_total++;
      if (dut_vec !== exp_vec)
        $display("FAIL rst_mid_run i=%0d: got %h want %h",
                 i, dut_vec, exp_vec);
      else n_pass++;
      if (bit_end && first_end < 0) first_end = i;
      advance();
    end
    n_total++;
    if (first_end != 3)
      $display("FAIL rst_mid_p4: got %0d want 3", first_end);
    else n_pass++;
  endtask

  task automatic test_cfg();
    drive(1'b0, 1'b0, 6'd2, 4'd10);
    advance();
`ifdef RX_TIMER_CFG_ERR_EN
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, 6'd2, 4'd10);
      n_total++;
      if (dut_vec !== exp_vec || (i > 0 && cfg_err !== 1'b1))
        $display("FAIL cfg_err i=%0d: got %h err %b want %h err 1",
                 i, dut_vec, cfg_err, exp_vec);
      else n_pass++;
      advance();
    end
    drive(1'b0, 1'b0, 6'd8, 4'd10);
    advance();
    drive(1'b0, 1'b0, 6'd8, 4'd10);
    n_total++;
    if (cfg_err !== 1'b0)
      $display("FAIL cfg_err_clr: got %b want 0", cfg_err);
    else n_pass++;
    advance();
`else
    begin
      int first_end;
      first_end = -1;
      for (int i = 0; i < 9; i++) begin
        drive(1'b0, 1'b1, 6'd2, 4'd10);
        n_total++;
        if (dut_vec !== exp_vec)
          $display("FAIL cfg_clamp i=%0d: got %h want %h",
                   i, dut_vec, exp_vec);
        else n_pass++;
        if (bit_end && first_end < 0) first_end = i;
        advance();
      end
      n_total++;
      if (first_end != 3)
        $display("FAIL cfg_clamp_period: got %0d want 3", first_end);
      else n_pass++;
    end
`endif
  endtask

  task automatic test_random();
    logic r, en;
    logic [PW-1:0] ps;
    logic [BW-1:0] fb;
    for (int i = 0; i < 800; i++) begin
      r = ($urandom_range(0, 59) == 0);
      en = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 9) == 0)
        ps = PW'($urandom_range(0, 63));
      else
        ps = PW'($urandom_range(2, 10));
      fb = BW'($urandom_range(0, 15));
      drive(r, en, ps, fb);
      n_total++;
      if (dut_vec !== exp_vec)
        $display("FAIL random i=%0d: got %h want %h",
                 i, dut_vec, exp_vec);
      else n_pass++;
`ifdef RX_TIMER_CFG_ERR_EN
      n_total++;
      if (cfg_err !== m_err)
        $display("FAIL random_err i=%0d: got %b want %b",
                 i, cfg_err, m_err);
      else n_pass++;
`endif
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_frame_p8();
    test_back_to_back();
    test_presc_change();
    test_enable_drop();
    test_reset_mid();
    test_cfg();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
